// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//   Programmable integer clock divider with a run/stop control FSM and a
//   glitch-free ratio switch. The divided clock is produced from a phase
//   counter (cnt = 0..N-1). clk_out is high while cnt < N/2, and tick marks
//   the first high cycle of every period. A ratio change requested while
//   running is held as "pending" and applied only at the next period
//   boundary, so no period is ever truncated.
//
// Parameters
//   CNT_W      width of the divide ratio / phase counter
//   RESET_DIV  divide ratio loaded by reset (2 .. 2^CNT_W-1)
//
// Ports
//   clk_in     single clock, rising edge
//   rst        asynchronous active-high reset
//   en         run request (stops only at a period boundary)
//   div_val    requested divide ratio N (0 and 1 are treated as 2)
//   div_valid  div_val offered
//   div_ready  ratio can be accepted (low while a switch is pending)
//   clk_out    divided clock (registered)
//   tick       one-cycle pulse on the first high cycle of each period
//   busy       divider running (RUN or SWITCH)
//   period_cnt 16-bit tick counter, present only when the macro
//              CLK_DIV_CTRL_PCOUNT_EN is defined
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
`ifdef CLK_DIV_CTRL_PCOUNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_RESET_N = CNT_W'(RESET_DIV);

  // Ratios below 2 cannot form a period with a high and a low phase.
  function automatic logic [CNT_W-1:0] f_clamp_div(input logic [CNT_W-1:0] v);
    if (v < CNT_W'(2)) begin
      return CNT_W'(2);
    end
    return v;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_n_nxt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic [CNT_W-1:0] w_div_clamped;
  logic             r_clk_out;
  logic             r_tick;
  logic             w_clk_out_nxt;
  logic             w_tick_nxt;
  logic             w_hs;
  logic             w_last;

  assign w_hs          = div_valid & div_ready;
  assign w_last        = (r_cnt == (r_n - CNT_W'(1)));
  assign w_div_clamped = f_clamp_div(div_val);

  // State register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STOP: begin
        if (en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Stopping at the boundary takes priority; a ratio accepted on that
        // same edge is loaded directly instead of entering SWITCH.
        if (w_last && !en) w_state_nxt = ST_STOP;
        else if (w_hs)     w_state_nxt = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (w_last) w_state_nxt = en ? ST_RUN : ST_STOP;
      end
      default: w_state_nxt = ST_STOP;
    endcase
  end

  // Datapath next values: phase counter, current ratio, pending ratio
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_n_nxt    = r_n;
    w_pend_nxt = r_pend;
    case (r_state)
      ST_STOP: begin
        w_cnt_nxt = '0;
        if (w_hs) w_n_nxt = w_div_clamped;
      end
      ST_RUN: begin
        w_cnt_nxt = w_last ? '0 : r_cnt + CNT_W'(1);
        if (w_hs) begin
          if (w_last && !en) w_n_nxt    = w_div_clamped;
          else               w_pend_nxt = w_div_clamped;
        end
      end
      ST_SWITCH: begin
        w_cnt_nxt = w_last ? '0 : r_cnt + CNT_W'(1);
        if (w_last) w_n_nxt = r_pend;
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  // Output logic. clk_out/tick are computed from the post-edge counter and
  // ratio so the registered outputs line up with the cycle cnt describes.
  always_comb begin
    div_ready     = (r_state != ST_SWITCH);
    busy          = (r_state != ST_STOP);
    w_tick_nxt    = (w_state_nxt != ST_STOP) && (w_cnt_nxt == '0);
    w_clk_out_nxt = (w_state_nxt != ST_STOP) && (w_cnt_nxt < (w_n_nxt >> 1));
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_n       <= LP_RESET_N;
      r_pend    <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_n       <= w_n_nxt;
      r_pend    <= w_pend_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;

`ifdef CLK_DIV_CTRL_PCOUNT_EN
  logic [15:0] r_period_cnt;

  // Counts in step with tick so the value seen during a tick already
  // includes that period; wraps naturally at 0xFFFF.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_period_cnt <= '0;
    end else if (w_tick_nxt) begin
      r_period_cnt <= r_period_cnt + 16'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_val;
  logic        div_valid;
  logic        div_ready;
  logic        clk_out;
  logic        tick;
  logic        busy;
`ifdef CLK_DIV_CTRL_PCOUNT_EN
  logic [15:0] period_cnt;
`endif

  clk_div_ctrl #(.CNT_W(16), .RESET_DIV(4)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_val   (div_val),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
`ifdef CLK_DIV_CTRL_PCOUNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic  c;
    logic  t;
    logic  b;
    logic  r;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_miscmp = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge,
  // then retrieve and compare them 1 time unit after that edge.
  task automatic step(input string tag, input logic e, input logic v, input logic [15:0] d,
                      input logic xc, input logic xt, input logic xb, input logic xr);
    exp_t x;
    exp_t y;
    en        = e;
    div_valid = v;
    div_val   = d;
    x.c = xc; x.t = xt; x.b = xb; x.r = xr; x.tag = tag;
    sb.push_back(x);
    @(posedge clk_in);
    #1;
    if (sb.size() == 0) begin
      chk_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      y = sb.pop_front();
      chk_eq({y.tag, "_clk_out"},   {31'd0, clk_out},   {31'd0, y.c});
      chk_eq({y.tag, "_tick"},      {31'd0, tick},      {31'd0, y.t});
      chk_eq({y.tag, "_busy"},      {31'd0, busy},      {31'd0, y.b});
      chk_eq({y.tag, "_div_ready"}, {31'd0, div_ready}, {31'd0, y.r});
    end
  endtask

  // Run with en=1 for reps periods; pat is the expected clk_out per cycle.
  task automatic run(input string tag, input string pat, input int reps,
                     input logic fv, input logic [15:0] fd);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < pat.len(); i++) begin
        step(tag, 1'b1, (r == 0 && i == 0) ? fv : 1'b0, fd,
             (pat[i] == 8'h31), (i == 0), 1'b1, 1'b1);
      end
    end
  endtask

  task automatic stop_step(input string tag);
    step(tag, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load(input string tag, input logic [15:0] d);
    step(tag, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    div_valid = 1'b0;
    div_val   = 16'd0;
    #12;
    chk_eq("rst_clk_out",   {31'd0, clk_out},   32'd0);
    chk_eq("rst_tick",      {31'd0, tick},      32'd0);
    chk_eq("rst_busy",      {31'd0, busy},      32'd0);
    chk_eq("rst_div_ready", {31'd0, div_ready}, 32'd1);
`ifdef CLK_DIV_CTRL_PCOUNT_EN
    chk_eq("rst_period_cnt", {16'd0, period_cnt}, 32'd0);
`endif
    @(posedge clk_in);
    #1 rst = 1'b0;

    // Reset ratio N=4
    run("n4", "1100", 3, 1'b0, 16'd0);
    stop_step("n4_stop");

    // Odd ratio accepted in STOP
    load("n5_load", 16'd5);
    run("n5", "11000", 3, 1'b0, 16'd0);
    stop_step("n5_stop");

    // Ratio 0 clamps to 2
    load("n0_load", 16'd0);
    run("n2", "10", 4, 1'b0, 16'd0);
    stop_step("n2_stop");

    // Handshake on the same edge en rises: first period already N=3
    run("hs_en", "100", 2, 1'b1, 16'd3);
    stop_step("hs_en_stop");

    // Switch 4 -> 6 requested at cnt=1; current period completes first
    load("sw_load", 16'd4);
    step("sw_c0", 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    step("sw_c1", 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("sw_c2", 1'b1, 1'b1, 16'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    step("sw_c3", 1'b1, 1'b1, 16'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    run("n6", "111000", 2, 1'b0, 16'd0);
    stop_step("n6_stop");

    // en dropped at cnt=1 of N=8: period completes, then STOP
    load("e8_load", 16'd8);
    step("e8_c0", 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    step("e8_c1", 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("e8_c2", 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("e8_c3", 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 4; i < 8; i++) begin
      step("e8_low", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    stop_step("e8_stop");
    stop_step("e8_idle");
    stop_step("e8_idle");

    // Reset during SWITCH with pending=10
    step("rs_c0", 1'b1, 1'b0, 16'd0,  1'b1, 1'b1, 1'b1, 1'b1);
    step("rs_c1", 1'b1, 1'b1, 16'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    div_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_eq("rs_async_clk_out",   {31'd0, clk_out},   32'd0);
    chk_eq("rs_async_tick",      {31'd0, tick},      32'd0);
    chk_eq("rs_async_busy",      {31'd0, busy},      32'd0);
    chk_eq("rs_async_div_ready", {31'd0, div_ready}, 32'd1);
`ifdef CLK_DIV_CTRL_PCOUNT_EN
    chk_eq("rs_period_cnt0", {16'd0, period_cnt}, 32'd0);
`endif
    @(posedge clk_in);
    #1 rst = 1'b0;
    run("rs_n4", "1100", 3, 1'b0, 16'd0);
`ifdef CLK_DIV_CTRL_PCOUNT_EN
    chk_eq("rs_period_cnt3", {16'd0, period_cnt}, 32'd3);
`endif
    stop_step("rs_stop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
